// File: rtl/display_ram_scheduler.sv
// Display RAM write-port scheduler: live capture always wins; rectangular fills use idle cycles.
// Optional FILL_CHECKER_EN: fill uses an 8x8 checkerboard of fill_color / ~fill_color.
module display_ram_scheduler #(
    parameter int ROW_W = 9,
    parameter int COL_W = 10,
    parameter int PIX_W = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   capture_req,
    input  logic [ROW_W+COL_W-1:0] capture_addr,
    input  logic [PIX_W-1:0]       capture_data,
    output logic                   capture_grant,
    input  logic                   fill_start,
    input  logic [PIX_W-1:0]       fill_color,
    input  logic [ROW_W-1:0]       fill_row_first,
    input  logic [ROW_W-1:0]       fill_row_last,
    input  logic [COL_W-1:0]       fill_col_last,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic [ROW_W+COL_W-1:0] ram_wraddress,
    output logic [PIX_W-1:0]       ram_data,
    output logic                   ram_wren
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        FILL,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [PIX_W-1:0]       color_q, color_d;
    logic [ROW_W-1:0]       row_first_q, row_first_d;
    logic [ROW_W-1:0]       row_last_q, row_last_d;
    logic [COL_W-1:0]       col_last_q, col_last_d;
    logic                   vsync_q, vsync_d;
    logic [ROW_W+COL_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]       data_q, data_d;
    logic                   wren_q, wren_d;
    logic                   grant_q, grant_d;
    logic [PIX_W-1:0]       fill_pix;
    logic                   frame_edge;

`ifdef FILL_CHECKER_EN
    always_comb begin
        fill_pix = (row_q[3] ^ col_q[3]) ? ~color_q : color_q;
    end
`else
    always_comb begin
        fill_pix = color_q;
    end
`endif

    assign frame_edge = vsync_q & ~vsync;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        color_d     = color_q;
        row_first_d = row_first_q;
        row_last_d  = row_last_q;
        col_last_d  = col_last_q;
        vsync_d     = vsync;
        addr_d      = addr_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        grant_d     = 1'b0;

        if (capture_req) begin
            wren_d  = 1'b1;
            grant_d = 1'b1;
            addr_d  = capture_addr;
            data_d  = capture_data;
        end

        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    color_d     = fill_color;
                    row_first_d = fill_row_first;
                    row_last_d  = fill_row_last;
                    col_last_d  = fill_col_last;
                    state_d     = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_edge) begin
                    row_d   = row_first_q;
                    col_d   = '0;
                    state_d = (row_first_q > row_last_q) ? DONE : FILL;
                end
            end
            FILL: begin
                // A cycle lost to capture leaves the counters on the same pixel
                if (!capture_req) begin
                    wren_d = 1'b1;
                    addr_d = {row_q, col_q};
                    data_d = fill_pix;
                    if (col_q == col_last_q) begin
                        col_d = '0;
                        if (row_q == row_last_q) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            color_q     <= '0;
            row_first_q <= '0;
            row_last_q  <= '0;
            col_last_q  <= '0;
            vsync_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            grant_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            color_q     <= color_d;
            row_first_q <= row_first_d;
            row_last_q  <= row_last_d;
            col_last_q  <= col_last_d;
            vsync_q     <= vsync_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            grant_q     <= grant_d;
        end
    end

    assign fill_busy     = (state_q == WAIT_FRAME) || (state_q == FILL);
    assign fill_done     = (state_q == DONE);
    assign ram_wraddress = addr_q;
    assign ram_data      = data_q;
    assign ram_wren      = wren_q;
    assign capture_grant = grant_q;

endmodule

// File: tb/tb_display_ram_scheduler.sv
// Directed self-checking bench for display_ram_scheduler.
module tb_display_ram_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        vsync;
    logic        capture_req;
    logic [18:0] capture_addr;
    logic [14:0] capture_data;
    logic        capture_grant;
    logic        fill_start;
    logic [14:0] fill_color;
    logic [8:0]  fill_row_first;
    logic [8:0]  fill_row_last;
    logic [9:0]  fill_col_last;
    logic        fill_busy;
    logic        fill_done;
    logic [18:0] ram_wraddress;
    logic [14:0] ram_data;
    logic        ram_wren;

    int checks = 0;
    int failures = 0;
    logic [18:0] wq[$];
    logic [14:0] dq[$];
    int cap_err;
    int done_idx;
    int ndone;
    int t3_done;
    int quiet_err;
    logic [14:0] chk_exp;

    display_ram_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .vsync          (vsync),
        .capture_req    (capture_req),
        .capture_addr   (capture_addr),
        .capture_data   (capture_data),
        .capture_grant  (capture_grant),
        .fill_start     (fill_start),
        .fill_color     (fill_color),
        .fill_row_first (fill_row_first),
        .fill_row_last  (fill_row_last),
        .fill_col_last  (fill_col_last),
        .fill_busy      (fill_busy),
        .fill_done      (fill_done),
        .ram_wraddress  (ram_wraddress),
        .ram_data       (ram_data),
        .ram_wren       (ram_wren)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_fill(input logic [8:0] rf, input logic [8:0] rl,
                              input logic [9:0] cl, input logic [14:0] col);
        fill_row_first = rf;
        fill_row_last  = rl;
        fill_col_last  = cl;
        fill_color     = col;
        fill_start     = 1'b1;
        step();
        fill_start     = 1'b0;
    endtask

    // Drops vsync, then runs ncyc cycles logging fill writes and capture results.
    task automatic run_fill(input int ncyc, input bit alt_cap);
        wq.delete();
        dq.delete();
        cap_err  = 0;
        done_idx = -1;
        ndone    = 0;
        vsync    = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            capture_req  = alt_cap & i[0];
            capture_addr = 19'h70000 + 19'(i);
            capture_data = 15'h1200 + 15'(i);
            step();
            if (capture_req) begin
                if (!(ram_wren && capture_grant &&
                      ram_wraddress == capture_addr &&
                      ram_data == capture_data))
                    cap_err++;
            end
            if (ram_wren && !capture_grant) begin
                wq.push_back(ram_wraddress);
                dq.push_back(ram_data);
            end
            if (fill_done) begin
                ndone++;
                done_idx = i;
                if (fill_busy) cap_err++;
            end
        end
        capture_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        vsync = 1'b1;
        capture_req = 1'b0;
        capture_addr = '0;
        capture_data = '0;
        fill_start = 1'b0;
        fill_color = '0;
        fill_row_first = '0;
        fill_row_last = '0;
        fill_col_last = '0;
        repeat (5) step();
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_wraddress, 0);
        check("rst_data", ram_data, 0);
        check("rst_grant", capture_grant, 0);
        check("rst_busy", fill_busy, 0);
        check("rst_done", fill_done, 0);
        reset = 1'b0;
        step();
        check("idle_wren", ram_wren, 0);

        // Test 1: hold after a capture pulse
        capture_req = 1'b1;
        capture_addr = 19'h00005;
        capture_data = 15'h7FFF;
        step();
        capture_req = 1'b0;
        step();
        check("hold_wren", ram_wren, 0);
        check("hold_addr", ram_wraddress, 19'h00005);
        check("hold_data", ram_data, 15'h7FFF);
        check("hold_grant", capture_grant, 0);

        // Test 2: capture write
        capture_req = 1'b1;
        capture_addr = 19'h12345;
        capture_data = 15'h7C00;
        step();
        capture_req = 1'b0;
        check("cap_wren", ram_wren, 1);
        check("cap_addr", ram_wraddress, 19'h12345);
        check("cap_data", ram_data, 15'h7C00);
        check("cap_grant", capture_grant, 1);

        // Test 3: fill rows 2..3, cols 0..3; second fill_start while busy ignored
        step();
        start_fill(9'd2, 9'd3, 10'd3, 15'h001F);
        check("t3_busy", fill_busy, 1);
        quiet_err = 0;
        fill_row_first = 9'd0;
        fill_row_last = 9'd9;
        fill_col_last = 10'd1;
        fill_color = 15'h0000;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        if (ram_wren) quiet_err++;
        repeat (3) begin
            step();
            if (ram_wren) quiet_err++;
        end
        check("t3_prewrites", quiet_err, 0);
        check("t3_busy_wait", fill_busy, 1);
        run_fill(14, 1'b0);
        check("t3_nwr", wq.size(), 8);
        check("t3_a0", wq[0], 19'h00800);
        check("t3_a3", wq[3], 19'h00803);
        check("t3_a4", wq[4], 19'h00C00);
        check("t3_a7", wq[7], 19'h00C03);
        check("t3_d0", dq[0], 15'h001F);
        check("t3_ndone", ndone, 1);
        check("t3_doneidx", done_idx, 8);
        check("t3_donebusy", cap_err, 0);
        check("t3_endbusy", fill_busy, 0);
        t3_done = done_idx;

        // Test 4: same fill with capture on alternate cycles
        vsync = 1'b1;
        step();
        start_fill(9'd2, 9'd3, 10'd3, 15'h001F);
        run_fill(24, 1'b1);
        check("t4_caperr", cap_err, 0);
        check("t4_nwr", wq.size(), 8);
        check("t4_a1", wq[1], 19'h00801);
        check("t4_a5", wq[5], 19'h00C01);
        check("t4_a7", wq[7], 19'h00C03);
        check("t4_ndone", ndone, 1);
        check("t4_doneidx", done_idx, 16);
        check("t4_later", done_idx > t3_done, 1);

        // Test 5: empty row range; fill_start in DONE cycle ignored
        vsync = 1'b1;
        step();
        start_fill(9'd5, 9'd4, 10'd3, 15'h001F);
        vsync = 1'b0;
        step();
        check("t5_done", fill_done, 1);
        check("t5_busy", fill_busy, 0);
        check("t5_wren", ram_wren, 0);
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        check("t5_ign_busy", fill_busy, 0);
        check("t5_ign_done", fill_done, 0);

        // Test 6: reset mid-fill, then a fresh fill
        vsync = 1'b1;
        step();
        start_fill(9'd0, 9'd1, 10'd15, 15'h001F);
        run_fill(4, 1'b0);
        check("t6_part", wq.size(), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_wren", ram_wren, 0);
        check("t6_rst_busy", fill_busy, 0);
        check("t6_rst_done", fill_done, 0);
        vsync = 1'b1;
        quiet_err = 0;
        repeat (4) begin
            step();
            if (ram_wren || fill_done || fill_busy) quiet_err++;
        end
        check("t6_quiet", quiet_err, 0);
        start_fill(9'd0, 9'd0, 10'd8, 15'h001F);
        check("t6_busy", fill_busy, 1);
        run_fill(14, 1'b0);
        check("t6_nwr", wq.size(), 9);
        check("t6_a8", wq[8], 19'h00008);
        check("t6_d0", dq[0], 15'h001F);
`ifdef FILL_CHECKER_EN
        chk_exp = 15'h7FE0;
`else
        chk_exp = 15'h001F;
`endif
        check("t6_d8", dq[8], chk_exp);
        check("t6_ndone", ndone, 1);
        check("t6_doneidx", done_idx, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
